// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmr_state_t;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WADR_W = ADDR_W - 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  // Word-address width for a DEPTH-entry array.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the MEM stage (master) and the responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_dm_word_array.sv
// DEPTH x 32 word storage: one synchronous write port, one combinational read port, async clear.
module dm_word_array
  import data_mem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, response after LATENCY cycles, errors for bad addresses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW = clog2(DEPTH);

  dmr_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              valid_q;
  logic              ready_q;

  logic              addr_err_c;
  logic              wr_en_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] mem_rdata;

  assign idx_c      = bus.req_addr[AW+1:2];
  assign addr_err_c = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[ADDR_W-1:2] >= WADR_W'(DEPTH));
  // Stores land in the array on the acceptance edge; errors never touch storage.
  assign wr_en_c    = (state == ST_IDLE) && bus.req_valid && bus.req_we && !addr_err_c;

  dm_word_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk_i),
    .rst_n (rst_i),
    .we    (wr_en_c),
    .waddr (idx_c),
    .wdata (bus.req_wdata),
    .raddr (idx_c),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= RSP_OK;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            err_q   <= addr_err_c ? RSP_ERR : RSP_OK;
            rdata_q <= (!bus.req_we && !addr_err_c) ? mem_rdata : '0;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state   <= ST_RESP;
              valid_q <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state   <= ST_RESP;
            valid_q <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= '0;
            err_q   <= RSP_OK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
